ss_multiplex_driver: RTL and testbench
======================================

SS_MULTIPLEX_DRIVER -- requirements
Module: ss_multiplex_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter DIV_WIDTH, default 17, log2 of clock cycles per digit slot (legal 5..24).
REQ-003 SHALL have port Clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Enable  input  1  high = scanning; low = display dark.
REQ-006 SHALL have port Load  input  1  one-cycle strobe capturing Chars/DP into shadow buffer.
REQ-007 SHALL have port Chars  input  8*NUM_DIGITS  character codes; byte i drives digit i.
REQ-008 SHALL have port DP  input  NUM_DIGITS  decimal point per digit, high = lit.
REQ-009 SHALL have port Brightness  input  4  PWM duty in sixteenths; 0 = dark.
REQ-010 SHALL have port SegmentDrivers  output  NUM_DIGITS  digit enables, active low.
REQ-011 SHALL have port SevenSegment  output  8  bit 7 = DP, bits 6:0 = g..a, active low.
REQ-012 SHALL have port FrameDone  output  1  one-cycle pulse after each full scan.

Function
REQ-013 SHALL hold slot counter SlotCnt (DIV_WIDTH bits) and digit index DigIdx (0..NUM_DIGITS-1).
REQ-014 SHALL, while Enable high, increment SlotCnt each cycle; on all-ones, wrap to 0 and advance DigIdx.
REQ-015 SHALL wrap DigIdx from NUM_DIGITS-1 to 0 for non-power-of-two NUM_DIGITS; no dead slots.
REQ-016 SHALL define frame boundary as the cycle with DigIdx = NUM_DIGITS-1 and SlotCnt all-ones.
REQ-017 SHALL assert FrameDone for exactly one cycle, one cycle after each frame boundary.
REQ-018 SHALL on Load copy Chars and DP into shadow registers and set Pending.
REQ-019 SHALL on a frame boundary with Pending set copy shadow into active registers and clear Pending; no mid-frame tearing.
REQ-020 SHALL, when Load and boundary coincide, commit the old shadow at this boundary, capture new data into shadow, and keep Pending set.
REQ-021 SHALL let the last Load before a boundary win; earlier uncommitted Loads are discarded.
REQ-022 SHALL lit digit DigIdx only while SlotCnt[DIV_WIDTH-1 -: 4] < Brightness; otherwise all SegmentDrivers high.
REQ-023 SHALL register SegmentDrivers and SevenSegment, so they lag the counter state by exactly one cycle.
REQ-024 SHALL drive SevenSegment = 8'hFF whenever no digit is lit.
REQ-025 SHALL, while Enable low, hold SlotCnt and DigIdx at 0, drive all outputs off, suppress FrameDone, and still accept Load.
REQ-026 SHALL decode character codes as 0x30-0x39 -> 0-9, 0x41-0x46 -> A-F, 0x2D -> minus (g only), all others blank.

Reset
REQ-027 SHALL on Reset low asynchronously set SegmentDrivers all-ones, SevenSegment 8'hFF, FrameDone 0.
REQ-028 SHALL on Reset low clear SlotCnt, DigIdx, Pending, and shadow/active chars (0x20 blank) and DP.
REQ-029 SHALL, when Reset is asserted mid-frame, discard pending data and restart at digit 0 after release.

Structure
REQ-030 SHALL place segment bit constants, SEG_BLANK, SEG_MINUS and character code constants in shared package ss_pkg.
REQ-031 SHALL implement decoding in sub-module ss_char_decode (8-bit code in, 7-bit active-high segments out, combinational).
REQ-032 SHALL instantiate exactly one ss_char_decode, fed by the active character at DigIdx; no per-digit decoders.

Verification (NUM_DIGITS=4, DIV_WIDTH=6, Brightness=15 unless stated)
REQ-033 SHALL check: Load "1234" (0x31..0x34), DP=4'b0100 -> after next boundary, digit 2 shows 7'b1001111 inverted with DP bit 7 low; digits scan 0,1,2,3 every 64 cycles.
REQ-034 SHALL check: Load "8888" mid-frame at DigIdx=1 -> digits 2,3 keep old chars until boundary; all show 8 from next frame.
REQ-035 SHALL check: Brightness=4 -> each digit driver low for 16 of 64 slot cycles; Brightness=0 -> SegmentDrivers stays 4'hF.
REQ-036 SHALL check: Load coincident with boundary -> old shadow shown next frame, new data the frame after; FrameDone pulses once per 256 cycles.
REQ-037 SHALL check: Enable low for 100 cycles mid-scan -> outputs off, no FrameDone; on re-enable scan resumes at digit 0, SlotCnt 0.
REQ-038 SHALL check: Reset asserted mid-frame with Pending set -> outputs off immediately (async), display blank after release until next Load.

Source files
------------

// File: rtl/ss_pkg.sv
// Shared constants for the seven-segment multiplexed display driver.
// Segment bit masks (bit0=a .. bit6=g, active high) and character codes.
package ss_pkg;

  localparam logic [6:0] SEG_A = 7'h01;
  localparam logic [6:0] SEG_B = 7'h02;
  localparam logic [6:0] SEG_C = 7'h04;
  localparam logic [6:0] SEG_D = 7'h08;
  localparam logic [6:0] SEG_E = 7'h10;
  localparam logic [6:0] SEG_F = 7'h20;
  localparam logic [6:0] SEG_G = 7'h40;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = SEG_G;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_F     = 8'h46;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_BLANK = 8'h20;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
      4'h1: s = SEG_B | SEG_C;
      4'h2: s = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
      4'h3: s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
      4'h4: s = SEG_B | SEG_C | SEG_F | SEG_G;
      4'h5: s = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
      4'h6: s = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
      4'h7: s = SEG_A | SEG_B | SEG_C;
      4'h8: s = 7'h7F;
      4'h9: s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
      4'hA: s = SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G;
      4'hB: s = SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
      4'hC: s = SEG_A | SEG_D | SEG_E | SEG_F;
      4'hD: s = SEG_B | SEG_C | SEG_D | SEG_E | SEG_G;
      4'hE: s = SEG_A | SEG_D | SEG_E | SEG_F | SEG_G;
      default: s = SEG_A | SEG_E | SEG_F | SEG_G;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ss_char_decode.sv
// Character code to seven-segment pattern decoder (combinational).
// code_i: 8-bit char code; seg_o: active-high segments g..a.
module ss_char_decode
  import ss_pkg::*;
(
  input  logic [7:0] code_i,
  output logic [6:0] seg_o
);

  logic is_dig;
  logic is_hex;
  logic is_min;

  assign is_dig = (code_i >= CH_0) && (code_i <= CH_9);
  assign is_hex = (code_i >= CH_A) && (code_i <= CH_F);
  assign is_min = (code_i == CH_MINUS);

  // 'A'..'F' low nibble is 1..6, so +9 lands on 0xA..0xF
  always_comb begin
    seg_o = SEG_BLANK;
    unique case (1'b1)
      is_dig:  seg_o = hex_seg(code_i[3:0]);
      is_hex:  seg_o = hex_seg(code_i[3:0] + 4'd9);
      is_min:  seg_o = SEG_MINUS;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ss_multiplex_driver.sv
// Multiplexed seven-segment driver: scan, PWM dimming, tear-free loads.
// Ports: Clk, Reset(async low), Enable, Load, Chars, DP, Brightness in; SegmentDrivers, SevenSegment, FrameDone out.
module ss_multiplex_driver
  import ss_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_WIDTH  = 17
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic                    Load,
  input  logic [8*NUM_DIGITS-1:0] Chars,
  input  logic [NUM_DIGITS-1:0]   DP,
  input  logic [3:0]              Brightness,
  output logic [NUM_DIGITS-1:0]   SegmentDrivers,
  output logic [7:0]              SevenSegment,
  output logic                    FrameDone
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  logic [DIV_WIDTH-1:0]    slot_q, slot_d;
  logic [IW-1:0]           dig_q, dig_d;
  logic                    pend_q, pend_d;
  logic [8*NUM_DIGITS-1:0] sh_ch_q, sh_ch_d;
  logic [8*NUM_DIGITS-1:0] act_ch_q, act_ch_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   drv_q, drv_d;
  logic [7:0]              seg_q, seg_d;
  logic                    fd_q, fd_d;

  logic       bnd;
  logic       lit;
  logic [7:0] cur_ch;
  logic       cur_dp;
  logic [6:0] cur_seg;

  assign bnd    = Enable & (&slot_q) & (dig_q == LAST);
  assign lit    = Enable & (slot_q[DIV_WIDTH-1 -: 4] < Brightness);
  assign cur_ch = 8'(act_ch_q >> {dig_q, 3'b000});
  assign cur_dp = 1'(act_dp_q >> dig_q);

  ss_char_decode u_dec (
    .code_i (cur_ch),
    .seg_o  (cur_seg)
  );

  always_comb begin
    slot_d   = '0;
    dig_d    = '0;
    pend_d   = pend_q;
    sh_ch_d  = sh_ch_q;
    sh_dp_d  = sh_dp_q;
    act_ch_d = act_ch_q;
    act_dp_d = act_dp_q;
    if (Enable) begin
      slot_d = slot_q + DIV_WIDTH'(1);
      dig_d  = dig_q;
      if (&slot_q)
        dig_d = (dig_q == LAST) ? '0 : dig_q + IW'(1);
    end
    // commit uses the pre-load shadow, so a coincident Load stays pending
    if (bnd && pend_q) begin
      act_ch_d = sh_ch_q;
      act_dp_d = sh_dp_q;
    end
    if (Load) begin
      sh_ch_d = Chars;
      sh_dp_d = DP;
      pend_d  = 1'b1;
    end else if (bnd) begin
      pend_d  = 1'b0;
    end
    drv_d = lit ? ~(NUM_DIGITS'(1) << dig_q) : '1;
    seg_d = lit ? {~cur_dp, ~cur_seg} : 8'hFF;
    fd_d  = bnd;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      slot_q   <= '0;
      dig_q    <= '0;
      pend_q   <= 1'b0;
      sh_ch_q  <= {NUM_DIGITS{CH_BLANK}};
      act_ch_q <= {NUM_DIGITS{CH_BLANK}};
      sh_dp_q  <= '0;
      act_dp_q <= '0;
      drv_q    <= '1;
      seg_q    <= 8'hFF;
      fd_q     <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      dig_q    <= dig_d;
      pend_q   <= pend_d;
      sh_ch_q  <= sh_ch_d;
      act_ch_q <= act_ch_d;
      sh_dp_q  <= sh_dp_d;
      act_dp_q <= act_dp_d;
      drv_q    <= drv_d;
      seg_q    <= seg_d;
      fd_q     <= fd_d;
    end
  end

  assign SegmentDrivers = drv_q;
  assign SevenSegment   = seg_q;
  assign FrameDone      = fd_q;

endmodule

// File: tb/tb_ss_multiplex_driver.sv
// Bench for ss_multiplex_driver (4 digits, 64-cycle slots).
// Scan-position reference model plus per-scenario checks.
module tb_ss_multiplex_driver;

  logic        Clk;
  logic        Reset;
  logic        Enable;
  logic        Load;
  logic [31:0] Chars;
  logic [3:0]  DP;
  logic [3:0]  Brightness;
  logic [3:0]  SegmentDrivers;
  logic [7:0]  SevenSegment;
  logic        FrameDone;

  int checks = 0;
  int errors = 0;

  ss_multiplex_driver #(
    .NUM_DIGITS (4),
    .DIV_WIDTH  (6)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Enable         (Enable),
    .Load           (Load),
    .Chars          (Chars),
    .DP             (DP),
    .Brightness     (Brightness),
    .SegmentDrivers (SegmentDrivers),
    .SevenSegment   (SevenSegment),
    .FrameDone      (FrameDone)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [6:0] ref_seg(input logic [7:0] c);
    string hexs;
    logic [6:0] t [16];
    hexs = "0123456789ABCDEF";
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    for (int i = 0; i < 16; i++)
      if (c == hexs[i]) return t[i];
    if (c == 8'h2D) return 7'h40;
    return 7'h00;
  endfunction

  // scan position = digit*64 + slot, one frame = 256 cycles
  int         m_pos;
  bit         m_pend;
  logic [7:0] m_sh [4];
  logic [7:0] m_act [4];
  logic [3:0] m_shdp, m_actdp;
  logic [3:0] e_sd;
  logic [7:0] e_ss;
  logic       e_fd;

  always @(posedge Clk or negedge Reset) begin : mdl
    int dig, slot;
    bit bnd, lit;
    if (!Reset) begin
      m_pos = 0; m_pend = 0;
      for (int i = 0; i < 4; i++) begin m_sh[i] = 8'h20; m_act[i] = 8'h20; end
      m_shdp = 0; m_actdp = 0;
      e_sd = 4'hF; e_ss = 8'hFF; e_fd = 1'b0;
    end else begin
      dig  = m_pos / 64;
      slot = m_pos % 64;
      bnd  = Enable && (m_pos == 255);
      lit  = Enable && ((slot / 4) < int'(Brightness));
      e_fd = bnd;
      e_sd = lit ? (4'hF & ~(4'b1 << dig)) : 4'hF;
      e_ss = lit ? {~m_actdp[dig], ~ref_seg(m_act[dig])} : 8'hFF;
      if (bnd && m_pend) begin
        for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
        m_actdp = m_shdp;
      end
      if (Load) begin
        for (int i = 0; i < 4; i++) m_sh[i] = Chars[8*i +: 8];
        m_shdp = DP;
        m_pend = 1;
      end else if (bnd) m_pend = 0;
      m_pos = Enable ? (m_pos + 1) % 256 : 0;
    end
  end

  task automatic test_reset();
    #1;
    checks++;
    if (SegmentDrivers !== 4'hF) begin errors++;
      $display("FAIL reset_sd got %h exp f", SegmentDrivers); end
    checks++;
    if (SevenSegment !== 8'hFF) begin errors++;
      $display("FAIL reset_ss got %h exp ff", SevenSegment); end
    checks++;
    if (FrameDone !== 1'b0) begin errors++;
      $display("FAIL reset_fd got %b exp 0", FrameDone); end
    @(negedge Clk);
    Reset = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge Clk);
      checks++;
      if ({SegmentDrivers, SevenSegment, FrameDone} !== {e_sd, e_ss, e_fd}) begin errors++;
        $display("FAIL model_reset got %h/%h/%b exp %h/%h/%b", SegmentDrivers, SevenSegment, FrameDone, e_sd, e_ss, e_fd); end
    end
  endtask

  task automatic test_load_scan();
    int hit;
    hit = 0;
    @(negedge Clk);
    Enable = 1'b1; Brightness = 4'd15;
    Chars = {8'h34, 8'h33, 8'h32, 8'h31}; DP = 4'b0100; Load = 1'b1;
    for (int n = 0; n < 600; n++) begin
      @(negedge Clk);
      Load = 1'b0;
      checks++;
      if ({SegmentDrivers, SevenSegment, FrameDone} !== {e_sd, e_ss, e_fd}) begin errors++;
        $display("FAIL model_scan got %h/%h/%b exp %h/%h/%b", SegmentDrivers, SevenSegment, FrameDone, e_sd, e_ss, e_fd); end
      if (SegmentDrivers == 4'b1011 && SevenSegment == 8'h30) hit++;
    end
    checks++;
    if (hit < 60) begin errors++;
      $display("FAIL digit2_3dp got %0d cycles exp >=60", hit); end
  endtask

  task automatic test_midframe();
    int k, old3, new8, bad;
    bit after;
    old3 = 0; new8 = 0; bad = 0; after = 0;
    for (k = 0; k < 400 && m_pos != 74; k++) @(negedge Clk);
    checks++;
    if (k >= 400) begin errors++;
      $display("FAIL mid_wait got timeout exp pos 74"); end
    Chars = {4{8'h38}}; DP = 4'b0000; Load = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(negedge Clk);
      Load = 1'b0;
      checks++;
      if ({SegmentDrivers, SevenSegment, FrameDone} !== {e_sd, e_ss, e_fd}) begin errors++;
        $display("FAIL model_mid got %h/%h/%b exp %h/%h/%b", SegmentDrivers, SevenSegment, FrameDone, e_sd, e_ss, e_fd); end
      if (!after) begin
        if (SegmentDrivers == 4'b1011 && SevenSegment == 8'h30) old3++;
        if (SegmentDrivers != 4'hF && SevenSegment == 8'h80) bad++;
        if (FrameDone) after = 1;
      end else if (SevenSegment == 8'h80) new8++;
    end
    checks++;
    if (old3 == 0 || bad != 0) begin errors++;
      $display("FAIL mid_tear got old3=%0d early8=%0d exp >0,0", old3, bad); end
    checks++;
    if (new8 < 240) begin errors++;
      $display("FAIL mid_eights got %0d exp >=240", new8); end
  endtask

  task automatic test_brightness();
    int cnt [4];
    int lit0;
    cnt = '{0, 0, 0, 0}; lit0 = 0;
    @(negedge Clk);
    Brightness = 4'd4;
    for (int n = 0; n < 256; n++) begin
      @(negedge Clk);
      checks++;
      if ({SegmentDrivers, SevenSegment, FrameDone} !== {e_sd, e_ss, e_fd}) begin errors++;
        $display("FAIL model_bri got %h/%h/%b exp %h/%h/%b", SegmentDrivers, SevenSegment, FrameDone, e_sd, e_ss, e_fd); end
      for (int d = 0; d < 4; d++)
        if (SegmentDrivers == (4'hF & ~(4'b1 << d))) cnt[d]++;
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cnt[d] != 16) begin errors++;
        $display("FAIL bri4_digit%0d got %0d exp 16", d, cnt[d]); end
    end
    Brightness = 4'd0;
    for (int n = 0; n < 256; n++) begin
      @(negedge Clk);
      if (SegmentDrivers != 4'hF) lit0++;
    end
    checks++;
    if (lit0 != 0) begin errors++;
      $display("FAIL bri0 got %0d lit cycles exp 0", lit0); end
    Brightness = 4'd15;
  endtask

  task automatic test_coincident();
    int k, nfd, ph, last, cA1, cM1, cM2;
    nfd = 0; ph = 0; last = 0; cA1 = 0; cM1 = 0; cM2 = 0;
    for (k = 0; k < 400 && m_pos != 100; k++) @(negedge Clk);
    Chars = {4{8'h41}}; DP = 4'b0000; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    for (k = 0; k < 400 && m_pos != 255; k++) @(negedge Clk);
    checks++;
    if (k >= 400) begin errors++;
      $display("FAIL coin_wait got timeout exp pos 255"); end
    Chars = {4{8'h2D}}; Load = 1'b1;
    for (int n = 1; n <= 768; n++) begin
      @(negedge Clk);
      Load = 1'b0;
      checks++;
      if ({SegmentDrivers, SevenSegment, FrameDone} !== {e_sd, e_ss, e_fd}) begin errors++;
        $display("FAIL model_coin got %h/%h/%b exp %h/%h/%b", SegmentDrivers, SevenSegment, FrameDone, e_sd, e_ss, e_fd); end
      if (ph == 1 && SevenSegment == 8'h88) cA1++;
      if (ph == 1 && SevenSegment == 8'hBF) cM1++;
      if (ph == 2 && SevenSegment == 8'hBF) cM2++;
      if (FrameDone) begin
        if (nfd > 0) begin
          checks++;
          if (n - last != 256) begin errors++;
            $display("FAIL fd_period got %0d exp 256", n - last); end
        end
        nfd++; ph++; last = n;
      end
    end
    checks++;
    if (nfd != 3) begin errors++;
      $display("FAIL fd_count got %0d exp 3", nfd); end
    checks++;
    if (cA1 < 240 || cM1 != 0) begin errors++;
      $display("FAIL coin_old got A=%0d minus=%0d exp >=240,0", cA1, cM1); end
    checks++;
    if (cM2 < 240) begin errors++;
      $display("FAIL coin_new got %0d exp >=240", cM2); end
  endtask

  task automatic test_enable();
    int k, tgt, bad;
    bad = 0;
    tgt = 30 + int'($urandom_range(0, 170));
    for (k = 0; k < 400 && m_pos != tgt; k++) @(negedge Clk);
    Enable = 1'b0;
    for (int n = 0; n < 100; n++) begin
      Load = (n == 40);
      Chars = {4{8'h35}};
      @(negedge Clk);
      if (SegmentDrivers != 4'hF || SevenSegment != 8'hFF || FrameDone) bad++;
    end
    Load = 1'b0;
    checks++;
    if (bad != 0) begin errors++;
      $display("FAIL en_off got %0d active cycles exp 0", bad); end
    Enable = 1'b1;
    @(negedge Clk);
    checks++;
    if (SegmentDrivers !== 4'b1110) begin errors++;
      $display("FAIL en_resume got %h exp e", SegmentDrivers); end
    for (int n = 0; n < 600; n++) begin
      @(negedge Clk);
      checks++;
      if ({SegmentDrivers, SevenSegment, FrameDone} !== {e_sd, e_ss, e_fd}) begin errors++;
        $display("FAIL model_en got %h/%h/%b exp %h/%h/%b", SegmentDrivers, SevenSegment, FrameDone, e_sd, e_ss, e_fd); end
    end
  endtask

  task automatic test_reset_mid();
    int k, bad;
    bad = 0;
    for (k = 0; k < 400 && m_pos != 50; k++) @(negedge Clk);
    Chars = {4{8'h37}}; DP = 4'b1111; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    repeat (20) @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (SegmentDrivers !== 4'hF || SevenSegment !== 8'hFF || FrameDone !== 1'b0) begin errors++;
      $display("FAIL rst_async got %h/%h/%b exp f/ff/0", SegmentDrivers, SevenSegment, FrameDone); end
    @(negedge Clk);
    Reset = 1'b1;
    for (int n = 0; n < 600; n++) begin
      @(negedge Clk);
      checks++;
      if ({SegmentDrivers, SevenSegment, FrameDone} !== {e_sd, e_ss, e_fd}) begin errors++;
        $display("FAIL model_rst got %h/%h/%b exp %h/%h/%b", SegmentDrivers, SevenSegment, FrameDone, e_sd, e_ss, e_fd); end
      if (SevenSegment != 8'hFF) bad++;
    end
    checks++;
    if (bad != 0) begin errors++;
      $display("FAIL rst_blank got %0d non-blank cycles exp 0", bad); end
  endtask

  task automatic test_random();
    logic [7:0] pool [8];
    pool = '{8'h30, 8'h39, 8'h41, 8'h46, 8'h2D, 8'h20, 8'h47, 8'h62};
    for (int n = 0; n < 3000; n++) begin
      @(negedge Clk);
      checks++;
      if ({SegmentDrivers, SevenSegment, FrameDone} !== {e_sd, e_ss, e_fd}) begin errors++;
        $display("FAIL model_rand got %h/%h/%b exp %h/%h/%b", SegmentDrivers, SevenSegment, FrameDone, e_sd, e_ss, e_fd); end
      Load = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < 4; i++)
        Chars[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
      DP = 4'($urandom);
      if ($urandom_range(0, 99) == 0) Brightness = 4'($urandom);
      if ($urandom_range(0, 149) == 0) Enable = ~Enable;
    end
    Load = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; Enable = 1'b0; Load = 1'b0;
    Chars = {4{8'h20}}; DP = 4'b0; Brightness = 4'd15;
    #12;
    test_reset();
    test_load_scan();
    test_midframe();
    test_brightness();
    test_coincident();
    test_enable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
